jamma_input_scanner: RTL

Time-multiplexed scanner for the JAMMA joystick bus. It drives the external player-select line and waits a settle window before sampling the shared 8-bit bus for each player. Each player's sample is debounced, and the on-board 6-bit joystick is merged into player 1. Coin inputs are synchronised and pulse-stretched. It sits between the JAMMA connector pins and the arcade core's joystick, player and coin inputs, in the pixel-clock domain.

---
 rtl/jamma_input_scanner.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/jamma_input_scanner.sv
// jamma_input_scanner: time-multiplexed two-player JAMMA joystick scanner with
// per-player debounce, on-board joystick merge into player 1, and coin stretch.
module jamma_input_scanner #(
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned DB_SAMPLES = 2,
    parameter int unsigned COIN_HOLD  = 16
) (
    input  logic       pclk_i,
    input  logic       reset_i,
    input  logic [7:0] jjoy_i,
    input  logic [1:0] jcoin_i,
    input  logic [5:0] local_joy_i,
    output logic       jselect_o,
    output logic [7:0] joy1_o,
    output logic [7:0] joy2_o,
    output logic [1:0] coin_o,
    output logic [1:0] sample_stb_o
);

    localparam int unsigned CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned HOLD_W = $clog2(COIN_HOLD + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [2:0]        DB_MAX      = 3'(DB_SAMPLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(COIN_HOLD);

    typedef enum logic [1:0] {
        S1_SETTLE,
        S1_SAMPLE,
        S2_SETTLE,
        S2_SAMPLE
    } state_t;

    // Synchroniser and edge-detect registers
    logic [7:0] jjoy_s1_q, jjoy_s2_q;
    logic [5:0] local_s1_q, local_s2_q;
    logic [1:0] jcoin_s1_q, jcoin_s2_q, jcoin_prev_q;

    // Scan FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             jselect_q, jselect_d;
    logic [1:0]       stb_q, stb_d;

    // Debounce, index 0 = player 1, index 1 = player 2
    logic [7:0] sample_c [2];
    logic       take_c   [2];
    logic [7:0] cand_q   [2];
    logic [7:0] cand_d   [2];
    logic [2:0] agree_q  [2];
    logic [2:0] agree_d  [2];
    logic [7:0] joy_q    [2];
    logic [7:0] joy_d    [2];

    // Coin stretch
    logic [HOLD_W-1:0] hold_q [2];
    logic [HOLD_W-1:0] hold_d [2];
    logic [1:0]        coin_q, coin_d;

    // Two-flop synchronisers (idle-high) plus previous coin level for edge detect
    always_ff @(posedge pclk_i) begin
        if (reset_i) begin
            jjoy_s1_q    <= '1;
            jjoy_s2_q    <= '1;
            local_s1_q   <= '1;
            local_s2_q   <= '1;
            jcoin_s1_q   <= '1;
            jcoin_s2_q   <= '1;
            jcoin_prev_q <= '1;
        end else begin
            jjoy_s1_q    <= jjoy_i;
            jjoy_s2_q    <= jjoy_s1_q;
            local_s1_q   <= local_joy_i;
            local_s2_q   <= local_s1_q;
            jcoin_s1_q   <= jcoin_i;
            jcoin_s2_q   <= jcoin_s1_q;
            jcoin_prev_q <= jcoin_s2_q;
        end
    end

    // Scan state register, select line and commit strobes
    always_ff @(posedge pclk_i) begin
        if (reset_i) begin
            state_q   <= S1_SETTLE;
            cnt_q     <= '0;
            jselect_q <= 1'b0;
            stb_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            jselect_q <= jselect_d;
            stb_q     <= stb_d;
        end
    end

    // Scan next-state: settle for SETTLE cycles, then sample for one cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S1_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S1_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S1_SAMPLE: begin
                state_d = S2_SETTLE;
                cnt_d   = '0;
            end
            S2_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S2_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S2_SAMPLE: begin
                state_d = S1_SETTLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S1_SETTLE;
                cnt_d   = '0;
            end
        endcase
        // Select tracks the upcoming state so it is high exactly during S2_*
        jselect_d = (state_d == S2_SETTLE) || (state_d == S2_SAMPLE);
        stb_d     = {state_q == S2_SAMPLE, state_q == S1_SAMPLE};
    end

    // Per-player sample source and sample enable
    always_comb begin
        sample_c[0] = jjoy_s2_q & {2'b11, local_s2_q};
        sample_c[1] = jjoy_s2_q;
        take_c[0]   = (state_q == S1_SAMPLE);
        take_c[1]   = (state_q == S2_SAMPLE);
    end

    // Debounce: commit once DB_SAMPLES consecutive samples agree
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            cand_d[p]  = cand_q[p];
            agree_d[p] = agree_q[p];
            joy_d[p]   = joy_q[p];
            if (take_c[p]) begin
                if (sample_c[p] == cand_q[p]) begin
                    if (agree_q[p] != DB_MAX) begin
                        agree_d[p] = agree_q[p] + 3'd1;
                    end
                end else begin
                    cand_d[p]  = sample_c[p];
                    agree_d[p] = 3'd1;
                end
                if (agree_d[p] == DB_MAX) begin
                    joy_d[p] = cand_d[p];
                end
            end
        end
    end

    // Debounce registers
    always_ff @(posedge pclk_i) begin
        if (reset_i) begin
            for (int p = 0; p < 2; p++) begin
                cand_q[p]  <= 8'hFF;
                agree_q[p] <= 3'd0;
                joy_q[p]   <= 8'hFF;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                cand_q[p]  <= cand_d[p];
                agree_q[p] <= agree_d[p];
                joy_q[p]   <= joy_d[p];
            end
        end
    end

    // Coin stretch: falling edge (re)loads the hold, output uses the next count
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            if (jcoin_prev_q[b] && !jcoin_s2_q[b]) begin
                hold_d[b] = HOLD_LOAD;
            end else if (hold_q[b] != '0) begin
                hold_d[b] = hold_q[b] - HOLD_W'(1);
            end else begin
                hold_d[b] = '0;
            end
            coin_d[b] = (hold_d[b] == '0) && jcoin_s2_q[b];
        end
    end

    // Coin hold counters and registered coin output
    always_ff @(posedge pclk_i) begin
        if (reset_i) begin
            for (int b = 0; b < 2; b++) begin
                hold_q[b] <= '0;
            end
            coin_q <= 2'b11;
        end else begin
            for (int b = 0; b < 2; b++) begin
                hold_q[b] <= hold_d[b];
            end
            coin_q <= coin_d;
        end
    end

    assign jselect_o    = jselect_q;
    assign joy1_o       = joy_q[0];
    assign joy2_o       = joy_q[1];
    assign coin_o       = coin_q;
    assign sample_stb_o = stb_q;

endmodule
